// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared types for the queued line rasteriser
package draw_pkg;
    localparam int CORDW = 10;
    localparam int PATW  = 8;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        DRAW
    } state_t;

    typedef struct packed {
        logic signed [CORDW-1:0] x0;
        logic signed [CORDW-1:0] y0;
        logic signed [CORDW-1:0] x1;
        logic signed [CORDW-1:0] y1;
        logic [PATW-1:0]         pat;
    } line_cmd_t;
endpackage

// File: rtl/line_cmd_fifo.sv
// rtl/line_cmd_fifo.sv - show-ahead command FIFO of line_cmd_t
module line_cmd_fifo
    import draw_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  line_cmd_t                wr_data,
    input  logic                     pop,
    output line_cmd_t                rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wp, rp;
    line_cmd_t   mem [DEPTH];
    logic        wr_en, rd_en;

    // Extra pointer bit distinguishes full from empty.
    assign level   = wp - rp;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (wp == rp);
    assign wr_en   = push && !full;
    assign rd_en   = pop && !empty;
    assign rd_data = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_en) wp <= wp + 1'b1;
            if (rd_en) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wp[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/draw_line_queue.sv
// rtl/draw_line_queue.sv - queued, clipped, dash-patterned Bresenham line drawer
module draw_line_queue
    import draw_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic signed [CORDW-1:0] cmd_x0,
    input  logic signed [CORDW-1:0] cmd_y0,
    input  logic signed [CORDW-1:0] cmd_x1,
    input  logic signed [CORDW-1:0] cmd_y1,
    input  logic [PATW-1:0]         cmd_pat,
    input  logic                    oe,
    output logic signed [CORDW-1:0] x,
    output logic signed [CORDW-1:0] y,
    output logic                    pix_valid,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(DEPTH):0]  fifo_level
);
    state_t                  state, state_next;
    line_cmd_t               cmd_in, head;
    logic                    full, empty, pop;
    logic signed [CORDW-1:0] xa, ya, xb, yb;
    logic signed [CORDW:0]   dx, dy, err;
    logic                    right;
    logic [PATW-1:0]         pat;

    assign cmd_in = '{x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1, pat: cmd_pat};

    line_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (cmd_valid),
        .wr_data (cmd_in),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    assign cmd_ready = !full;
    assign busy      = (state != IDLE) || (fifo_level != '0);

    logic step_en, at_end, movx, movy, swap;
    logic signed [CORDW+1:0] err2, dx2, dy2;
    logic signed [CORDW-1:0] hxa, hya, hxb, hyb;
    logic signed [CORDW:0]   hdx, hdy;

    assign step_en = (state == DRAW) && oe;
    assign at_end  = (x == xb) && (y == yb);
    assign err2    = {err[CORDW], err, 1'b0};
    assign dx2     = {dx[CORDW], dx};
    assign dy2     = {dy[CORDW], dy};
    assign movx    = err2 >= dy2;
    assign movy    = err2 <= dx2;

    // Head command normalised so the line always runs downward.
    always_comb begin
        swap = head.y0 > head.y1;
        hxa  = swap ? head.x1 : head.x0;
        hya  = swap ? head.y1 : head.y0;
        hxb  = swap ? head.x0 : head.x1;
        hyb  = swap ? head.y0 : head.y1;
        hdx  = {hxb[CORDW-1], hxb} - {hxa[CORDW-1], hxa};
        hdy  = {hya[CORDW-1], hya} - {hyb[CORDW-1], hyb};
    end

    assign pix_valid = step_en && pat[PATW-1]
                    && int'(x) >= 0 && int'(x) < H_RES
                    && int'(y) >= 0 && int'(y) < V_RES;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop        = 1'b1;
                state_next = INIT;
            end
            INIT: state_next = DRAW;
            DRAW: if (oe && at_end) begin
                pop        = !empty;
                state_next = empty ? IDLE : INIT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0; y <= '0;
            xa <= '0; ya <= '0; xb <= '0; yb <= '0;
            dx <= '0; dy <= '0; err <= '0;
            right <= 1'b0;
            pat <= '0;
            done <= 1'b0;
        end else begin
            done <= step_en && at_end;
            if (state == INIT) begin
                err <= dx + dy;
                x   <= xa;
                y   <= ya;
            end else if (step_en) begin
                pat <= {pat[PATW-2:0], pat[PATW-1]};
                if (!at_end) begin
                    if (movx) x <= right ? x + CORDW'(1) : x - CORDW'(1);
                    if (movy) y <= y + CORDW'(1);
                    if (movx && movy)  err <= err + dx + dy;
                    else if (movx)     err <= err + dy;
                    else if (movy)     err <= err + dx;
                end
            end
            // Placed last so a pop on the final pixel wins over the pattern rotate.
            if (pop) begin
                xa    <= hxa;
                ya    <= hya;
                xb    <= hxb;
                yb    <= hyb;
                right <= hxa < hxb;
                dx    <= hdx[CORDW] ? -hdx : hdx;
                dy    <= hdy;
                pat   <= head.pat;
            end
        end
    end
endmodule

// File: tb/tb_draw_line_queue.sv
// tb/tb_draw_line_queue.sv - self-checking bench for draw_line_queue
module tb_draw_line_queue;
    import draw_pkg::*;
    localparam int DEPTH = 4;
    localparam int H_RES = 640;
    localparam int V_RES = 480;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    logic signed [CORDW-1:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
    logic [PATW-1:0] cmd_pat = '0;
    logic oe = 1'b1;
    logic signed [CORDW-1:0] x, y;
    logic pix_valid, busy, done;
    logic [$clog2(DEPTH):0] fifo_level;

    draw_line_queue #(.DEPTH(DEPTH), .H_RES(H_RES), .V_RES(V_RES)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_pat(cmd_pat), .oe(oe), .x(x), .y(y), .pix_valid(pix_valid),
        .busy(busy), .done(done), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int exp_x[$], exp_y[$];
    int done_seen = 0, done_exp = 0, pix_seen = 0;
    bit rand_oe = 0, saw_full = 0;

    task automatic check(string tag, int obs, int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: plain integer Bresenham, visible pixels appended in draw order.
    function automatic int model_line(int x0, int y0, int x1, int y1, logic [7:0] p);
        int xa, ya, xb, yb, dx, dy, err, e2, sx, n, cx, cy;
        if (y0 > y1) begin xa = x1; ya = y1; xb = x0; yb = y0; end
        else         begin xa = x0; ya = y0; xb = x1; yb = y1; end
        dx = (xb > xa) ? xb - xa : xa - xb;
        dy = -(yb - ya);
        err = dx + dy;
        sx = (xa < xb) ? 1 : -1;
        cx = xa; cy = ya; n = 0;
        forever begin
            if (p[7 - (n % 8)] && cx >= 0 && cx < H_RES && cy >= 0 && cy < V_RES) begin
                exp_x.push_back(cx);
                exp_y.push_back(cy);
            end
            n++;
            if (cx == xb && cy == yb) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; cx += sx; end
            if (e2 <= dx) begin err += dx; cy += 1; end
        end
        return n;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (pix_valid) begin
            pix_seen++;
            check("pix_pending", int'(exp_x.size() > 0), 1);
            if (exp_x.size() > 0) begin
                check("pix_x", int'(x), exp_x.pop_front());
                check("pix_y", int'(y), exp_y.pop_front());
            end
        end
        if (done) done_seen++;
        if (fifo_level == DEPTH) begin
            saw_full = 1;
            check("ready_when_full", int'(cmd_ready), 0);
        end
        @(posedge clk);
        #1;
        if (rand_oe) oe = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push(int x0, int y0, int x1, int y1, logic [7:0] p);
        int b = 0;
        int s;
        while (!cmd_ready && b < 300) begin tick(); b++; end
        if (b == 300) check("push_timeout", int'(cmd_ready), 1);
        cmd_x0 = x0[CORDW-1:0]; cmd_y0 = y0[CORDW-1:0];
        cmd_x1 = x1[CORDW-1:0]; cmd_y1 = y1[CORDW-1:0];
        cmd_pat = p;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        s = model_line(x0, y0, x1, y1, p);
        done_exp++;
    endtask

    task automatic run_until_done(output int first_j, output int done_j);
        int d0 = done_seen, p0 = pix_seen, j = 0;
        first_j = -1;
        done_j = -1;
        while (done_seen == d0 && j < 100) begin
            tick();
            j++;
            if (first_j < 0 && pix_seen != p0) first_j = j;
        end
        if (done_seen != d0) done_j = j;
    endtask

    task automatic wait_idle(int maxc);
        int c = 0;
        while (busy && c < maxc) begin tick(); c++; end
        check("drain_busy", int'(busy), 0);
        tick();
        tick();
    endtask

    initial begin
        int fj, dj, p0, hx, hy, d0, b;
        repeat (2) @(posedge clk);
        #1;
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_pix_valid", int'(pix_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_ready", int'(cmd_ready), 1);
        rst_n = 1'b1;
        tick();

        // Horizontal solid line: latency and done timing.
        push(0, 0, 3, 0, 8'hFF);
        run_until_done(fj, dj);
        check("t1_first_pix_cycle", fj, 3);
        check("t1_done_cycle", dj, 7);
        check("t1_busy_after", int'(busy), 0);
        check("t1_x_end", int'(x), 3);

        // Swapped endpoints.
        push(3, 3, 0, 0, 8'hFF);
        run_until_done(fj, dj);
        check("t2_done_cycle", dj, 7);
        check("t2_queue_empty", exp_x.size(), 0);

        // Dash pattern.
        p0 = pix_seen;
        push(0, 0, 7, 0, 8'b1100_1100);
        run_until_done(fj, dj);
        check("t3_done_cycle", dj, 11);
        check("t3_pix_count", pix_seen - p0, 4);

        // Entirely clipped diagonal.
        p0 = pix_seen;
        push(-2, 478, 1, 481, 8'hFF);
        run_until_done(fj, dj);
        check("t4_done_cycle", dj, 7);
        check("t4_pix_count", pix_seen - p0, 0);

        // Queue fill while a long line draws.
        saw_full = 0;
        push(0, 0, 20, 0, 8'hFF);
        push(5, 5, 8, 9, 8'hFF);
        push(10, 2, 3, 2, 8'hAA);
        push(0, 10, 0, 14, 8'hFF);
        push(7, 7, 7, 7, 8'hFF);
        push(20, 30, 14, 25, 8'hF0);
        wait_idle(500);
        check("t5_saw_full", int'(saw_full), 1);
        check("t5_done_count", done_seen, done_exp);
        check("t5_queue_empty", exp_x.size(), 0);

        // Output-enable stall mid-line.
        p0 = pix_seen;
        push(0, 0, 15, 5, 8'hFF);
        b = 0;
        while (pix_seen - p0 < 4 && b < 50) begin tick(); b++; end
        check("t6_reached_mid", int'(pix_seen - p0 >= 4), 1);
        oe = 1'b0;
        hx = int'(x);
        hy = int'(y);
        repeat (3) begin
            tick();
            check("t6_hold_x", int'(x), hx);
            check("t6_hold_y", int'(y), hy);
            check("t6_hold_pix", int'(pix_valid), 0);
        end
        oe = 1'b1;
        b = 0;
        while (pix_seen - p0 < 7 && b < 50) begin tick(); b++; end
        push(1, 1, 9, 9, 8'hFF);
        push(2, 2, 4, 4, 8'hFF);

        // Asynchronous reset mid-line.
        d0 = done_seen;
        rst_n = 1'b0;
        #1;
        check("t6_rst_x", int'(x), 0);
        check("t6_rst_y", int'(y), 0);
        check("t6_rst_pix", int'(pix_valid), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_done", int'(done), 0);
        check("t6_rst_level", int'(fifo_level), 0);
        check("t6_rst_ready", int'(cmd_ready), 1);
        exp_x.delete();
        exp_y.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("t6_no_done", done_seen, d0);
        check("t6_idle", int'(busy), 0);
        done_seen = 0;
        done_exp = 0;

        // Randomised commands with random output enable.
        rand_oe = 1;
        for (int i = 0; i < 14; i++) begin
            int ax, ay, bx, by, ybase;
            ybase = ($urandom_range(0, 1) == 0) ? 0 : 455;
            ax = $urandom_range(0, 60); ax -= 15;
            bx = $urandom_range(0, 60); bx -= 15;
            ay = $urandom_range(0, 40); ay += ybase - 10;
            by = $urandom_range(0, 40); by += ybase - 10;
            push(ax, ay, bx, by, ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
        end
        rand_oe = 0;
        oe = 1'b1;
        wait_idle(5000);
        check("rand_done_count", done_seen, done_exp);
        check("rand_queue_empty", exp_x.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
